// File: rtl/simple_adder_pkg.sv
// Shared constants and helpers for the 4-operand signed adder.
// Used by simple_adder and simple_adder_add2.
package simple_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 25;
  localparam int unsigned MAX_WIDTH     = 64;
  localparam int unsigned EXT_WIDTH     = MAX_WIDTH + 2;

  // Largest positive value representable in 'width' signed bits.
  function automatic logic signed [MAX_WIDTH-1:0] sat_max(input int unsigned width);
    logic [MAX_WIDTH:0] one_shl;
    one_shl = (MAX_WIDTH+1)'(1) << (width - 1);
    return MAX_WIDTH'(one_shl - (MAX_WIDTH+1)'(1));
  endfunction

  // Most negative value representable in 'width' signed bits.
  function automatic logic signed [MAX_WIDTH-1:0] sat_min(input int unsigned width);
    logic [MAX_WIDTH:0] one_shl;
    one_shl = (MAX_WIDTH+1)'(1) << (width - 1);
    return MAX_WIDTH'((MAX_WIDTH+1)'(0) - one_shl);
  endfunction

  // Sign-extend a 'width'-bit value held in a 64-bit container to 66 bits.
  function automatic logic signed [EXT_WIDTH-1:0] ext2(input logic signed [MAX_WIDTH-1:0] x,
                                                       input int unsigned width);
    logic signed [MAX_WIDTH-1:0] t;
    t = x <<< (MAX_WIDTH - width);
    t = t >>> (MAX_WIDTH - width);
    return EXT_WIDTH'(t);
  endfunction

endpackage

// File: rtl/simple_adder_add2.sv
// Combinational signed 2-input adder; the result is one bit wider than the
// inputs so the sum can never overflow.
module simple_adder_add2
  import simple_adder_pkg::*;
#(
  parameter int unsigned IW = DEFAULT_WIDTH
) (
  input  logic signed [IW-1:0] a_i,
  input  logic signed [IW-1:0] b_i,
  output logic signed [IW:0]   sum_c_o
);

  logic signed [IW:0] a_x;
  logic signed [IW:0] b_x;

  assign a_x     = (IW+1)'(a_i);
  assign b_x     = (IW+1)'(b_i);
  assign sum_c_o = a_x + b_x;

endmodule

// File: rtl/simple_adder.sv
// Registered 4-operand signed adder with overflow flag.
// Define SIMPLE_ADDER_SAT_EN to clamp RES on overflow instead of wrapping.
module simple_adder
  import simple_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic signed [WIDTH-1:0] WORD_0,
  input  logic signed [WIDTH-1:0] WORD_1,
  input  logic signed [WIDTH-1:0] WORD_2,
  input  logic signed [WIDTH-1:0] WORD_3,
  output logic signed [WIDTH-1:0] RES,
  output logic                    OVF
);

  localparam int unsigned SW = WIDTH + 2;

  // Signed range limits, widened to the exact-sum width for comparison.
  localparam logic signed [SW-1:0] MAX_X = SW'(ext2(sat_max(WIDTH), WIDTH));
  localparam logic signed [SW-1:0] MIN_X = SW'(ext2(sat_min(WIDTH), WIDTH));

  logic signed [WIDTH:0]   sum01_c;
  logic signed [WIDTH:0]   sum23_c;
  logic signed [SW-1:0]    sum_c;

  logic signed [WIDTH-1:0] res_d;
  logic signed [WIDTH-1:0] res_q;
  logic                    ovf_d;
  logic                    ovf_q;

  simple_adder_add2 #(.IW(WIDTH)) u_add01 (
    .a_i     (WORD_0),
    .b_i     (WORD_1),
    .sum_c_o (sum01_c)
  );

  simple_adder_add2 #(.IW(WIDTH)) u_add23 (
    .a_i     (WORD_2),
    .b_i     (WORD_3),
    .sum_c_o (sum23_c)
  );

  simple_adder_add2 #(.IW(WIDTH + 1)) u_add_fin (
    .a_i     (sum01_c),
    .b_i     (sum23_c),
    .sum_c_o (sum_c)
  );

  // Overflow detection on the exact sum, then wrap or clamp.
  always_comb begin
    ovf_d = (sum_c > MAX_X) || (sum_c < MIN_X);
    res_d = sum_c[WIDTH-1:0];
`ifdef SIMPLE_ADDER_SAT_EN
    if (ovf_d) begin
      res_d = sum_c[SW-1] ? MIN_X[WIDTH-1:0] : MAX_X[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign RES = res_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_simple_adder.sv
// Scoreboard bench for simple_adder (WIDTH=25); honours SIMPLE_ADDER_SAT_EN.
module tb_simple_adder;

  localparam int unsigned W    = 25;
  localparam longint      MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint      MINV = -(longint'(1) <<< (W - 1));

  typedef struct {
    logic signed [W-1:0] res;
    logic                ovf;
    string               tag;
  } exp_t;

  logic                CLK;
  logic                RST_N;
  logic signed [W-1:0] WORD_0;
  logic signed [W-1:0] WORD_1;
  logic signed [W-1:0] WORD_2;
  logic signed [W-1:0] WORD_3;
  logic signed [W-1:0] RES;
  logic                OVF;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  simple_adder #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .WORD_0 (WORD_0),
    .WORD_1 (WORD_1),
    .WORD_2 (WORD_2),
    .WORD_3 (WORD_3),
    .RES    (RES),
    .OVF    (OVF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string name, input logic signed [63:0] act,
                           input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input longint a, input longint b, input longint c,
                                 input longint d, input string tag);
    exp_t   e;
    longint s;
    s     = a + b + c + d;
    e.ovf = (s > MAXV) || (s < MINV);
    e.res = W'(s);
`ifdef SIMPLE_ADDER_SAT_EN
    if (e.ovf) e.res = (s > 0) ? W'(MAXV) : W'(MINV);
`endif
    e.tag = tag;
    return e;
  endfunction

  task automatic drive(input longint a, input longint b, input longint c, input longint d);
    WORD_0 = W'(a);
    WORD_1 = W'(b);
    WORD_2 = W'(c);
    WORD_3 = W'(d);
  endtask

  // Drive operands for the next rising edge and queue the hand-computed result.
  task automatic apply_exp(input longint a, input longint b, input longint c, input longint d,
                           input longint er, input logic eo, input string tag);
    exp_t e;
    @(negedge CLK);
    drive(a, b, c, d);
    e.res = W'(er);
    e.ovf = eo;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: one result per rising edge while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (RST_N === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_val({e.tag, ".res"}, RES, e.res);
        check_val({e.tag, ".ovf"}, {63'd0, OVF}, {63'd0, e.ovf});
      end
    end
  end

  initial begin
    logic signed [W-1:0] r0, r1, r2, r3;
    exp_t                e;
    checks = 0;
    errors = 0;
    RST_N  = 1'b0;
    drive(0, 0, 0, 0);

    #1;
    check_val("rst_init.res", RES, 0);
    check_val("rst_init.ovf", {63'd0, OVF}, 0);
    repeat (4) begin
      @(negedge CLK);
      drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      @(posedge CLK);
      #1;
      check_val("rst_hold.res", RES, 0);
      check_val("rst_hold.ovf", {63'd0, OVF}, 0);
    end
    @(negedge CLK);
    RST_N = 1'b1;

    apply_exp(1, 2, 3, 4, 10, 1'b0, "basic");
    apply_exp(1, 2, 3, 4, 10, 1'b0, "hold");
    apply_exp(-1, 0, 3, 4, 6, 1'b0, "signed");

    // Mid-cycle operand changes must not reach RES before the next edge.
    @(posedge CLK);
    #2;
    WORD_2 = W'(5);
    #1;
    WORD_0 = W'(0);
    e.res = W'(9);
    e.ovf = 1'b0;
    e.tag = "midcycle";
    sb_q.push_back(e);
    #1;
    check_val("glitch_hold.res", RES, 6);
    #3;
    check_val("glitch_hold2.res", RES, 6);

`ifdef SIMPLE_ADDER_SAT_EN
    apply_exp(16777215, 16777215, 16777215, 16777215, 16777215, 1'b1, "pos_ovf");
    apply_exp(-16777216, -16777216, -16777216, -16777216, -16777216, 1'b1, "neg_ovf");
    apply_exp(16777215, 1, 0, 0, 16777215, 1'b1, "pos_edge_ovf");
    apply_exp(-16777216, -1, 0, 0, -16777216, 1'b1, "neg_edge_ovf");
`else
    apply_exp(16777215, 16777215, 16777215, 16777215, -4, 1'b1, "pos_ovf");
    apply_exp(-16777216, -16777216, -16777216, -16777216, 0, 1'b1, "neg_ovf");
    apply_exp(16777215, 1, 0, 0, -16777216, 1'b1, "pos_edge_ovf");
    apply_exp(-16777216, -1, 0, 0, 16777215, 1'b1, "neg_edge_ovf");
`endif
    apply_exp(16777215, 0, 0, 0, 16777215, 1'b0, "max_no_ovf");
    apply_exp(-16777216, 0, 0, 0, -16777216, 1'b0, "min_no_ovf");
    apply_exp(16777215, 16777215, -16777216, -16777216, -2, 1'b0, "mixed_cancel");

    // Asynchronous reset between edges.
    apply_exp(1, 2, 3, 4, 10, 1'b0, "pre_rst");
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check_val("async_rst.res", RES, 0);
    check_val("async_rst.ovf", {63'd0, OVF}, 0);
    @(posedge CLK);
    #1;
    check_val("rst_edge.res", RES, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check_val("post_rst.res", RES, 10);
    check_val("post_rst.ovf", {63'd0, OVF}, 0);

    for (int i = 0; i < 10000; i++) begin
      r0 = W'($urandom);
      r1 = W'($urandom);
      r2 = W'($urandom);
      r3 = W'($urandom);
      @(negedge CLK);
      drive(r0, r1, r2, r3);
      sb_q.push_back(model(r0, r1, r2, r3, "rand"));
    end

    @(posedge CLK);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
